run_fifo: RTL
=============

// Module: run_fifo
// PURPOSE
//  First-word-fall-through FIFO carrying sorted runs into one merger input
//  (A or B). A data word of zero terminates a run. Exposes head word,
//  empty/full and a head-is-terminator flag for the merger control. Also
//  counts buffered complete runs for the upstream stage.
// PARAMETERS
//  DATA_W   32  width of one record; value 0 is the run terminator
//  DEPTH    16  entries; power of two, >= 4
//  ADDR_W   4   log2(DEPTH); must match DEPTH
//  AF_LEVEL 12  o_almost_full asserts when count >= AF_LEVEL
// PORTS
//  i_clk          in   1         clock, all state on rising edge
//  i_rst_n        in   1         asynchronous active-low reset
//  i_wr_en        in   1         push i_wr_data this cycle
//  i_wr_data      in   DATA_W    word to push
//  o_full         out  1         count == DEPTH
//  o_almost_full  out  1         count >= AF_LEVEL
//  i_rd_en        in   1         pop head this cycle (merger !stall & select)
//  o_rd_data      out  DATA_W    head word (FWFT); 0 when empty
//  o_empty        out  1         count == 0
//  o_head_zero    out  1         !o_empty & (o_rd_data == 0): head ends a run
//  o_count        out  ADDR_W+1  entries held, 0..DEPTH
//  o_runs         out  ADDR_W+1  terminators held, 0..DEPTH
//  o_overflow     out  1         sticky: write refused
//  o_underflow    out  1         sticky: read on empty
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): pointers, count, runs = 0; o_empty=1;
//    o_full=o_almost_full=o_head_zero=0; o_rd_data=0; sticky flags = 0.
//    Reset mid-transfer discards all contents; no partial state kept.
//  - Storage: DEPTH x DATA_W array, wr_ptr/rd_ptr ADDR_W bits, wrap modulo
//    DEPTH naturally; count held separately (ADDR_W+1 bits), no ptr compare.
//  - Accept rules (flags from registered count, evaluated pre-edge):
//      rd_ok = i_rd_en & !o_empty
//      wr_ok = i_wr_en & (!o_full | rd_ok)   (full + pop + push allowed)
//  - Refusals: i_wr_en & !wr_ok sets o_overflow; i_rd_en & o_empty sets
//    o_underflow. Both hold until reset. Refused ops change no other state.
//  - Empty + push + pop same cycle: push accepted, pop refused (no bypass),
//    o_underflow set.
//  - Latency: word pushed at edge N visible on o_rd_data after edge N
//    (same cycle as o_empty falls). Pop at edge N advances head after N.
//  - count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither.
//  - runs: +1 if wr_ok & i_wr_data==0; -1 if rd_ok & head==0; net on both.
//  - o_rd_data = mem[rd_ptr] when !o_empty, else 0 (never stale).
//  - o_head_zero never asserts while empty (merger must not see a phantom
//    terminator on an empty input; it tests a_empty first).
//  - All outputs combinational from registered state only; no path from
//    i_rd_en/i_wr_en to any output in the same cycle.
// TESTING
//  1 Reset: hold i_rst_n=0 mid-fill (count=5) -> count=0, o_empty=1,
//    o_rd_data=0, o_runs=0, sticky flags 0, asynchronously before next edge.
//  2 Fill: push 1..16 (DEPTH=16) -> o_almost_full after 12th, o_full after
//    16th; 17th push -> refused, o_overflow=1, count stays 16, head still 1.
//  3 Full push+pop: at count=16 push 99 & pop -> count 16, head becomes 2,
//    99 read 16th later; o_overflow stays 0.
//  4 Runs: push 5,7,0,3,0 -> o_runs=2; pop 3 words -> o_head_zero=1 before
//    3rd pop, o_runs=1 after; drain -> o_runs=0, o_head_zero=0.
//  5 Empty: pop on empty -> o_underflow=1, count 0; push 8 & pop same cycle
//    on empty -> count=1, o_rd_data=8 next cycle.
//  6 Wrap: 40 random push/pop cycles vs model queue -> o_rd_data, o_count,
//    o_runs match every cycle across >=2 pointer wraps.

Source files
------------

// File: rtl/run_fifo.sv
// First-word-fall-through FIFO feeding one merger input with sorted runs.
// A zero word terminates a run; buffered terminators are counted for upstream.
module run_fifo #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_full,
   output logic              o_almost_full,
   input  logic              i_rd_en,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_empty,
   output logic              o_head_zero,
   output logic [ADDR_W:0]   o_count,
   output logic [ADDR_W:0]   o_runs,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   runs;
   logic              overflow;
   logic              underflow;

   logic              empty;
   logic              full;
   logic              rd_ok;
   logic              wr_ok;
   logic              push_term;
   logic              pop_term;
   logic [DATA_W-1:0] head;

   assign empty     = (count == '0);
   assign full      = (count == FULL_LVL);
   assign head      = mem[rd_ptr];

   // A pop on a full FIFO frees the slot the simultaneous push needs.
   assign rd_ok     = i_rd_en & ~empty;
   assign wr_ok     = i_wr_en & (~full | rd_ok);
   assign push_term = wr_ok & (i_wr_data == '0);
   assign pop_term  = rd_ok & (head == '0);

   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         runs      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         case ({push_term, pop_term})
            2'b10:   runs <= runs + 1'b1;
            2'b01:   runs <= runs - 1'b1;
            default: runs <= runs;
         endcase
         if (i_wr_en & ~wr_ok) begin
            overflow <= 1'b1;
         end
         if (i_rd_en & empty) begin
            underflow <= 1'b1;
         end
      end
   end

   // Outputs depend on registered state only; an empty FIFO shows a clean zero.
   assign o_rd_data     = empty ? '0 : head;
   assign o_empty       = empty;
   assign o_full        = full;
   assign o_almost_full = (count >= AF_LVL);
   assign o_head_zero   = ~empty & (head == '0);
   assign o_count       = count;
   assign o_runs        = runs;
   assign o_overflow    = overflow;
   assign o_underflow   = underflow;

endmodule
